seq_detector_param: RTL
=======================

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 Parameter PAT_W, default 8: maximum pattern length in bits, legal range 2..32.
REQ-002 Parameter CNT_W, default 8: width of the match counter.
REQ-003 Derived localparam LEN_W = clog2(PAT_W+1); it is not user-settable.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_a_p  input  1  asynchronous, active-high reset.
REQ-006 din_valid  input  1  din is sampled on this cycle.
REQ-007 din  input  1  serial data bit.
REQ-008 cfg_load  input  1  single-cycle pulse that latches the cfg_* inputs.
REQ-009 cfg_pattern  input  PAT_W  target pattern; bit [len-1] is the first bit received, bit [0] the last.
REQ-010 cfg_len  input  LEN_W  pattern length; legal range 1..PAT_W.
REQ-011 cfg_overlap  input  1  1 = overlapping matches allowed; 0 = history restarts after each match.
REQ-012 cnt_clr  input  1  synchronous clear of match_count.
REQ-013 match  output  1  registered single-cycle pulse per detected pattern.
REQ-014 match_count  output  CNT_W  saturating count of matches.
REQ-015 armed  output  1  high when a valid configuration is held (state FILL or RUN).
REQ-016 cfg_err  output  1  registered single-cycle pulse when cfg_load carries an illegal cfg_len.

Function
REQ-017 The block SHALL implement states IDLE (no configuration held), FILL (fill < len) and RUN (fill == len).
REQ-018 Internal registers: pattern (PAT_W), len (LEN_W), overlap (1), history shift register hist (PAT_W), fill counter (LEN_W, saturating at len).
REQ-019 cfg_load with 1 <= cfg_len <= PAT_W SHALL, on the next edge:
  - latch pattern, len and overlap;
  - clear hist and fill;
  - enter FILL from any state.
REQ-020 cfg_load with cfg_len == 0 or cfg_len > PAT_W SHALL:
  - pulse cfg_err for one cycle;
  - leave state, configuration, hist and fill unchanged.
REQ-021 If cfg_load and din_valid are high in the same cycle, the configuration load SHALL take precedence and that din bit SHALL be discarded.
REQ-022 In IDLE, din_valid SHALL be ignored and match SHALL stay 0.
REQ-023 In FILL or RUN, each din_valid cycle SHALL perform these updates:
  - hist <= {hist[PAT_W-2:0], din};
  - fill <= min(fill+1, len).
REQ-024 A hit SHALL be declared on a din_valid cycle when both hold:
  - (fill+1) >= len;
  - the low len bits of {hist[PAT_W-2:0], din} equal the low len bits of pattern.
  Bits of pattern above len-1 SHALL be don't-care.
REQ-025 On a hit, match SHALL be 1 on the cycle after the completing bit is sampled (latency 1) and SHALL be 0 otherwise.
REQ-026 On a hit with overlap=0, fill SHALL be set to 0 and the state SHALL return to FILL; hist still shifts.
REQ-027 On a hit with overlap=1, fill SHALL remain at len and the state SHALL remain RUN.
REQ-028 The FILL->RUN transition SHALL occur on the edge where fill reaches len without a non-overlap hit.
REQ-029 match_count SHALL increment by 1 on each hit and SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-030 cnt_clr SHALL set match_count to 0; cnt_clr together with a hit SHALL result in match_count = 1.
REQ-031 din_valid low SHALL freeze hist, fill and state; match SHALL be 0 on the following cycle.
REQ-032 With len == 1, every valid bit equal to pattern[0] SHALL produce a hit, regardless of overlap.

Reset
REQ-033 rst_a_p high SHALL immediately force:
  - state = IDLE;
  - pattern, len, overlap, hist and fill = 0;
  - match = 0, match_count = 0, armed = 0, cfg_err = 0.
REQ-034 Reset asserted mid-stream SHALL discard all partial history; after release, no match is possible until a new cfg_load.
REQ-035 Reset deassertion SHALL take effect from the next rising clk edge.

Verification
REQ-036 Load pattern=4'b1001, len=4, overlap=1; stream 1,0,0,1,0,0,1 -> match pulses after bits 4 and 7; match_count = 2.
REQ-037 Same stream with overlap=0 -> match only after bit 4; match_count = 1.
REQ-038 cfg_len = 0, then cfg_len = PAT_W+1 -> cfg_err pulses twice; armed, state and count unchanged; stream 1,1 while IDLE -> no match.
REQ-039 CNT_W=2, pattern=1'b1, len=1; five consecutive valid 1s -> match_count 1,2,3,3,3; cnt_clr coincident with the 6th hit -> match_count = 1.
REQ-040 Assert rst_a_p after bits 1,0,0 of 1001 -> outputs are 0 immediately; after release plus reload, bit 1 alone gives no match; full 1,0,0,1 gives one match.
REQ-041 PAT_W=8, len=8, pattern=8'hA5, bits streamed with din_valid gaps and a cfg_load colliding with a valid bit -> collided bit discarded; match exactly one cycle after the 8th accepted bit.

Source files
------------

// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-loadable pattern, length and overlap mode.
// Emits a registered pulse per match and keeps a saturating match count.
module seq_detector_param #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  localparam int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst_a_p,
  input  logic             din_valid,
  input  logic             din,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             armed,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state, w_state_nxt;
  logic [PAT_W-1:0] r_pattern, w_pattern_nxt;
  logic [PAT_W-1:0] r_hist, w_hist_nxt;
  logic [LEN_W-1:0] r_len, w_len_nxt;
  logic [LEN_W-1:0] r_fill, w_fill_nxt;
  logic             r_overlap, w_overlap_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic             r_match, r_cfg_err;

  logic [PAT_W:0]   w_full;
  logic [PAT_W-1:0] w_mask;
  logic [LEN_W:0]   w_fill_inc;
  logic             w_cfg_ok, w_accept, w_hit;

  assign w_cfg_ok   = (cfg_len != {LEN_W{1'b0}}) && (cfg_len <= MAX_LEN);
  assign w_accept   = (r_state != S_IDLE) && din_valid && !cfg_load;
  // The bit shifted out of the history is carried along so the compare can mask it off.
  assign w_full     = {r_hist, din};
  assign w_fill_inc = {1'b0, r_fill} + {{LEN_W{1'b0}}, 1'b1};

  always_comb begin
    w_mask = {PAT_W{1'b0}};
    for (int i = 0; i < PAT_W; i++) begin
      w_mask[i] = (i < int'(r_len));
    end
  end

  assign w_hit = w_accept && (w_fill_inc >= {1'b0, r_len}) &&
                 (((w_full ^ {1'b0, r_pattern}) & {1'b0, w_mask}) == {(PAT_W + 1){1'b0}});

  always_comb begin
    w_state_nxt   = r_state;
    w_pattern_nxt = r_pattern;
    w_len_nxt     = r_len;
    w_overlap_nxt = r_overlap;
    w_hist_nxt    = r_hist;
    w_fill_nxt    = r_fill;
    if (cfg_load) begin
      if (w_cfg_ok) begin
        w_pattern_nxt = cfg_pattern;
        w_len_nxt     = cfg_len;
        w_overlap_nxt = cfg_overlap;
        w_hist_nxt    = {PAT_W{1'b0}};
        w_fill_nxt    = {LEN_W{1'b0}};
        w_state_nxt   = S_FILL;
      end else begin
        w_state_nxt   = r_state;
      end
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_IDLE;
        S_FILL, S_RUN: begin
          if (din_valid) begin
            w_hist_nxt = w_full[PAT_W-1:0];
            if (w_hit && !r_overlap) begin
              w_fill_nxt  = {LEN_W{1'b0}};
              w_state_nxt = S_FILL;
            end else if (w_fill_inc >= {1'b0, r_len}) begin
              w_fill_nxt  = r_len;
              w_state_nxt = S_RUN;
            end else begin
              w_fill_nxt  = w_fill_inc[LEN_W-1:0];
              w_state_nxt = S_FILL;
            end
          end else begin
            w_state_nxt = r_state;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // A clear coinciding with a hit leaves exactly that hit counted.
  always_comb begin
    w_count_nxt = r_count;
    if (cnt_clr) begin
      w_count_nxt = w_hit ? CNT_W'(1) : {CNT_W{1'b0}};
    end else if (w_hit && (r_count != CNT_MAX)) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else begin
      w_count_nxt = r_count;
    end
  end

  always_ff @(posedge clk or posedge rst_a_p) begin
    if (rst_a_p) begin
      r_state   <= S_IDLE;
      r_pattern <= {PAT_W{1'b0}};
      r_len     <= {LEN_W{1'b0}};
      r_overlap <= 1'b0;
      r_hist    <= {PAT_W{1'b0}};
      r_fill    <= {LEN_W{1'b0}};
      r_count   <= {CNT_W{1'b0}};
      r_match   <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pattern <= w_pattern_nxt;
      r_len     <= w_len_nxt;
      r_overlap <= w_overlap_nxt;
      r_hist    <= w_hist_nxt;
      r_fill    <= w_fill_nxt;
      r_count   <= w_count_nxt;
      r_match   <= w_hit;
      r_cfg_err <= cfg_load && !w_cfg_ok;
    end
  end

  assign match       = r_match;
  assign match_count = r_count;
  assign armed       = (r_state != S_IDLE);
  assign cfg_err     = r_cfg_err;

endmodule
